// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave with one-word tx buffer and rx holding register.
module spi_slave #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_clk,
  input  logic          spi_cs,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          rx_ovf,
  output logic          tx_unf,
  output logic          busy
);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sclk_s_q, sclk_s_d, cs_s_q, cs_s_d, mosi_s_q, mosi_s_d;
  logic            sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic [1:0]      settle_q, settle_d;
  logic            arm_q, arm_d;
  logic [DW-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DW-1:0]   tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic            tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
  logic            rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            sclk_rise, sclk_fall, cs_fall, cs_rise, in_shift;
  logic            cap, word_end, load, shift, tx_acc;
  logic [DW-1:0]   rx_word;
  // Edge detection, word load/shift control and host-side handshakes.
  // arm_q blocks a chip select that was already low when reset released.
  always_comb begin
    sclk_s_d    = {sclk_s_q[0], spi_clk};
    cs_s_d      = {cs_s_q[0], spi_cs};
    mosi_s_d    = {mosi_s_q[0], spi_mosi};
    sclk_prev_d = sclk_s_q[1];
    cs_prev_d   = cs_s_q[1];
    settle_d    = settle_q + 2'(settle_q != 2'd3);
    arm_d       = arm_q | (&settle_q & cs_s_q[1]);
    sclk_rise   = sclk_s_q[1] & ~sclk_prev_q;
    sclk_fall   = ~sclk_s_q[1] & sclk_prev_q;
    cs_fall     = arm_q & cs_prev_q & ~cs_s_q[1];
    cs_rise     = ~cs_prev_q & cs_s_q[1];
    in_shift    = state_q == SHIFT;
    cap         = in_shift & ~cs_rise & sclk_rise;
    word_end    = cap & (bit_cnt_q == CW'(DW - 1));
    load        = (~in_shift & cs_fall) | (in_shift & ~cs_rise & sclk_fall & (bit_cnt_q == CW'(DW)));
    shift       = in_shift & ~cs_rise & sclk_fall & (bit_cnt_q != CW'(DW));
    tx_acc      = tx_valid & ~tx_full_q;
    rx_word     = {rx_sr_q[DW-2:0], mosi_s_q[1]};
    state_d     = cs_rise ? IDLE : (~in_shift & cs_fall) ? SHIFT : state_q;
    tx_sr_d     = load ? (tx_full_q ? tx_buf_q : '0) : shift ? {tx_sr_q[DW-2:0], 1'b0} : tx_sr_q;
    tx_unf_d    = load & ~tx_full_q;
    tx_full_d   = tx_acc | (tx_full_q & ~load);
    tx_buf_d    = tx_acc ? tx_data : tx_buf_q;
    bit_cnt_d   = load ? '0 : cap ? bit_cnt_q + CW'(1) : bit_cnt_q;
    rx_sr_d     = cap ? rx_word : rx_sr_q;
    rx_data_d   = word_end ? rx_word : rx_data_q;
    rx_valid_d  = word_end | (rx_valid_q & ~rx_ready);
    rx_ovf_d    = word_end & rx_valid_q & ~rx_ready;
  end
  // State register; synchronizers reset to idle bus levels (clock low, CS high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_s_q    <= 2'b00;
      cs_s_q      <= 2'b11;
      mosi_s_q    <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= 2'd0;
      arm_q       <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      tx_buf_q    <= '0;
      rx_data_q   <= '0;
      tx_full_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
      tx_unf_q    <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sclk_s_q    <= sclk_s_d;
      cs_s_q      <= cs_s_d;
      mosi_s_q    <= mosi_s_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      settle_q    <= settle_d;
      arm_q       <= arm_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      tx_full_q   <= tx_full_d;
      rx_valid_q  <= rx_valid_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_unf_q    <= tx_unf_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end
  assign spi_miso = in_shift & tx_sr_q[DW-1];
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ovf   = rx_ovf_q;
  assign tx_unf   = tx_unf_q;
  assign busy     = ~cs_s_q[1];
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed mode-0 transfers against spi_slave with DW=8.
module tb_spi_slave;
  logic       clk = 0, rst = 1, spi_clk = 0, spi_cs = 1, spi_mosi = 0;
  logic       tx_valid = 0, rx_ready = 0;
  logic [7:0] tx_data = 0;
  logic       spi_miso, tx_ready, rx_valid, rx_ovf, tx_unf, busy;
  logic [7:0] rx_data;
  int         n_vec = 0, n_bad = 0, unf_cnt = 0, ovf_cnt = 0, lat;
  logic [7:0] rxq[$];
  spi_slave #(.DW(8)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_ovf(rx_ovf),
    .tx_unf(tx_unf), .busy(busy)
  );
  always #5 clk = ~clk;
  // Count pulses and log every rx handshake.
  always @(posedge clk) begin
    if (tx_unf) unf_cnt <= unf_cnt + 1;
    if (rx_ovf) ovf_cnt <= ovf_cnt + 1;
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end
  task wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task tx_load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask
  task cs_start;
    spi_cs = 0;
    wait_clk(6);
  endtask
  task cs_end;
    spi_cs = 1;
    wait_clk(6);
    spi_clk = 0;
    wait_clk(6);
  endtask
  task rx_consume;
    rx_ready = 1;
    wait_clk(1);
    rx_ready = 0;
  endtask
  task spi_bits(input logic [7:0] w, input int nb, output logic [7:0] r);
    r = 0;
    lat = -1;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_clk = 0;
      spi_mosi = w[i];
      wait_clk(6);
      r[i] = spi_miso;
      spi_clk = 1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (rx_valid && lat < 0) lat = k;
      end
    end
  endtask
  task test_reset;
    wait_clk(3);
    n_vec++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_vec++; if ({rx_valid, rx_ovf, tx_unf, busy, spi_miso} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {rx_valid, rx_ovf, tx_unf, busy, spi_miso}); end
    n_vec++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    rst = 0;
    wait_clk(6);
  endtask
  task test_basic;
    logic [7:0] r;
    int u;
    u = unf_cnt;
    tx_load(8'hA5);
    n_vec++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_tx_full: got %b want 0", tx_ready); end
    cs_start;
    n_vec++; if ({busy, tx_ready} !== 2'b11) begin n_bad++; $display("FAIL basic_busy_ready: got %b want 11", {busy, tx_ready}); end
    spi_bits(8'h3C, 8, r);
    n_vec++; if (r !== 8'hA5) begin n_bad++; $display("FAIL basic_miso: got %h want a5", r); end
    n_vec++; if (!(lat >= 1 && lat <= 4)) begin n_bad++; $display("FAIL basic_latency: got %0d want 1..4", lat); end
    cs_end;
    n_vec++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL basic_rx_data: got %h want 3c", rx_data); end
    n_vec++; if ({rx_valid, tx_ready, busy} !== 3'b110) begin n_bad++; $display("FAIL basic_status: got %b want 110", {rx_valid, tx_ready, busy}); end
    n_vec++; if (unf_cnt - u !== 0) begin n_bad++; $display("FAIL basic_unf: got %0d want 0", unf_cnt - u); end
    rx_consume;
    n_vec++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume: got %b want 0", rx_valid); end
  endtask
  task test_back_to_back;
    logic [7:0] r;
    int u, o, b;
    u = unf_cnt; o = ovf_cnt; b = rxq.size();
    tx_load(8'hA5);
    rx_ready = 1;
    cs_start;
    tx_load(8'h81);
    spi_bits(8'h11, 8, r);
    n_vec++; if (r !== 8'hA5) begin n_bad++; $display("FAIL b2b_miso0: got %h want a5", r); end
    spi_bits(8'h22, 8, r);
    n_vec++; if (r !== 8'h81) begin n_bad++; $display("FAIL b2b_miso1: got %h want 81", r); end
    cs_end;
    n_vec++;
    if (rxq.size() != b + 2) begin n_bad++; $display("FAIL b2b_rx_count: got %0d want 2", rxq.size() - b); end
    else if ({rxq[b], rxq[b+1]} !== 16'h1122) begin n_bad++; $display("FAIL b2b_rx_seq: got %h %h want 11 22", rxq[b], rxq[b+1]); end
    n_vec++; if ({unf_cnt - u, ovf_cnt - o} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL b2b_unf_ovf: got %0d %0d want 0 0", unf_cnt - u, ovf_cnt - o); end
    n_vec++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rx_valid: got %b want 0", rx_valid); end
    rx_ready = 0;
  endtask
  task test_underflow;
    logic [7:0] r;
    int u;
    u = unf_cnt;
    cs_start;
    spi_bits(8'h96, 8, r);
    n_vec++; if (r !== 8'h00) begin n_bad++; $display("FAIL unf_miso: got %h want 00", r); end
    cs_end;
    n_vec++; if (unf_cnt - u !== 1) begin n_bad++; $display("FAIL unf_pulses: got %0d want 1", unf_cnt - u); end
    n_vec++; if (rx_data !== 8'h96) begin n_bad++; $display("FAIL unf_rx_data: got %h want 96", rx_data); end
    rx_consume;
  endtask
  task test_overflow;
    logic [7:0] r;
    int o;
    o = ovf_cnt;
    cs_start;
    spi_bits(8'h11, 8, r);
    spi_bits(8'h22, 8, r);
    cs_end;
    n_vec++; if (ovf_cnt - o !== 1) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - o); end
    n_vec++; if ({rx_valid, rx_data} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL ovf_rx: got %b/%h want 1/22", rx_valid, rx_data); end
    rx_consume;
  endtask
  task test_abort;
    logic [7:0] r;
    tx_load(8'hE7);
    cs_start;
    spi_bits(8'hFF, 5, r);
    n_vec++; if (r !== 8'hE0) begin n_bad++; $display("FAIL abort_partial_miso: got %h want e0", r); end
    cs_end;
    n_vec++; if ({rx_valid, spi_miso, busy, tx_ready} !== 4'b0001) begin n_bad++; $display("FAIL abort_status: got %b want 0001", {rx_valid, spi_miso, busy, tx_ready}); end
    cs_start;
    spi_bits(8'h5A, 8, r);
    n_vec++; if (r !== 8'h00) begin n_bad++; $display("FAIL abort_no_retx: got %h want 00", r); end
    cs_end;
    n_vec++; if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL abort_next_rx: got %b/%h want 1/5a", rx_valid, rx_data); end
  endtask
  task test_reset_mid;
    logic [7:0] r;
    tx_load(8'h99);
    cs_start;
    spi_bits(8'hC3, 3, r);
    rst = 1;
    wait_clk(2);
    n_vec++; if ({rx_valid, rx_ovf, tx_unf, busy, spi_miso, tx_ready} !== 6'b000001) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000001", {rx_valid, rx_ovf, tx_unf, busy, spi_miso, tx_ready}); end
    n_vec++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    spi_clk = 0;
    wait_clk(2);
    rst = 0;
    wait_clk(6);
    n_vec++; if ({busy, spi_miso} !== 2'b10) begin n_bad++; $display("FAIL rstmid_held_cs: got %b want 10", {busy, spi_miso}); end
    spi_bits(8'hFF, 8, r);
    n_vec++; if ({rx_valid, r} !== 9'h000) begin n_bad++; $display("FAIL rstmid_no_stale_xfer: got %b/%h want 0/00", rx_valid, r); end
    cs_end;
    tx_load(8'h4B);
    cs_start;
    spi_bits(8'hC3, 8, r);
    n_vec++; if (r !== 8'h4B) begin n_bad++; $display("FAIL rstmid_miso: got %h want 4b", r); end
    cs_end;
    n_vec++; if ({rx_valid, rx_data} !== {1'b1, 8'hC3}) begin n_bad++; $display("FAIL rstmid_rx: got %b/%h want 1/c3", rx_valid, rx_data); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_underflow;
    test_overflow;
    test_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DW, default 8: SPI word width in bits, 2..32.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 spi_clk  input  1  SPI serial clock from master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005 spi_cs  input  1  chip select from master, active-low, asynchronous.
REQ-006 spi_mosi  input  1  serial data from master, MSB first.
REQ-007 spi_miso  output  1  serial data to master, MSB first.
REQ-008 tx_data  input  DW  next word to send.
REQ-009 tx_valid  input  1  tx_data valid.
REQ-010 tx_ready  output  1  tx buffer empty; the word is accepted on a cycle where tx_valid and tx_ready are both high.
REQ-011 rx_data  output  DW  last received word.
REQ-012 rx_valid  output  1  rx_data holds an unread word.
REQ-013 rx_ready  input  1  host consumes rx_data on a cycle where rx_valid and rx_ready are both high.
REQ-014 rx_ovf  output  1  one-cycle pulse: a received word overwrote an unread word.
REQ-015 tx_unf  output  1  one-cycle pulse: a word was loaded while the tx buffer was empty.
REQ-016 busy  output  1  high while spi_cs is synchronized low.

Function
REQ-017 spi_clk, spi_cs and spi_mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals; clk SHALL be at least 8x spi_clk.
REQ-018 States SHALL be IDLE and SHIFT; IDLE->SHIFT on the synchronized spi_cs falling edge; SHIFT->IDLE on the synchronized spi_cs rising edge, from any bit position.
REQ-019 Word load, at IDLE->SHIFT and at each word boundary inside SHIFT: shift register <= tx buffer if full, else all zeros with a tx_unf pulse; the buffer becomes empty; bit counter <= 0.
REQ-020 spi_miso SHALL equal the shift register MSB while in SHIFT and 0 in IDLE.
REQ-021 On each synchronized spi_clk rising edge in SHIFT, the synchronized mosi SHALL be captured into the receive shift register LSB (left shift), and the bit counter SHALL increment.
REQ-022 On each synchronized spi_clk falling edge in SHIFT, the transmit shift register SHALL shift left one bit, except on the falling edge that follows a word completion, when the reload of REQ-019 occurs instead.
REQ-023 Word completion, on the DW-th rising edge: rx_data <= the received word and rx_valid <= 1 on the following clk edge; if rx_valid was already 1 and is not consumed that same cycle, rx_ovf SHALL pulse and the new word SHALL overwrite.
REQ-024 rx_valid SHALL clear on handshake; when a handshake and a completion coincide, rx_valid SHALL stay 1 with the new data and rx_ovf SHALL NOT pulse.
REQ-025 tx_ready SHALL be high exactly when the tx buffer is empty; when a tx accept and a word load coincide, the loaded word SHALL be the old buffer content or zero, and the buffer SHALL hold the new word afterwards.
REQ-026 Chip-select deassert mid-word: the partial receive word SHALL be discarded, rx_valid and rx_data SHALL be unchanged, and the consumed tx word SHALL NOT be retransmitted.
REQ-027 Latency: rx_valid SHALL rise within 4 clk cycles of the raw spi_clk rising edge that completes the word.
REQ-028 Edges of spi_clk while spi_cs is high SHALL be ignored.

Reset
REQ-029 While rst is high: state IDLE, shift registers and counter 0, tx buffer empty, tx_ready=1, rx_data=0, rx_valid=0, rx_ovf=0, tx_unf=0, busy=0, spi_miso=0; synchronizers load the idle levels spi_clk=0 and spi_cs=1.
REQ-030 Reset asserted mid-transfer SHALL abort immediately; after release, the block SHALL wait for a fresh spi_cs falling edge.

Verification
REQ-031 DW=8, tx 0xA5 preloaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1, tx_ready=1.
REQ-032 Two words in one CS, tx buffer refilled with 0x81 in between; master sends 0x11,0x22 -> MISO 0xA5 then 0x81; rx sequence 0x11,0x22 with rx_ready held high; no ovf/unf.
REQ-033 Empty tx buffer at CS low -> MISO all zeros for the word, tx_unf pulses once.
REQ-034 rx_ready held low across words 0x11 and 0x22 -> rx_data=0x22, rx_ovf pulses once.
REQ-035 CS raised after 5 bits of 0xFF -> rx_valid stays 0, state IDLE, spi_miso=0; the next full word 0x5A is received correctly.
REQ-036 rst pulse at bit 3 -> all outputs at REQ-029 values; a subsequent transfer of 0xC3 is received correctly.
